// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - pin-side and control-side signal bundle for input_conditioner
//
// Purpose: groups the raw input pins, per-channel enables and conditioned
// outputs of one input_conditioner instance.
//
// Signals (bit i = channel i):
//   i_din     raw asynchronous input pins
//   i_chan_en synchronous per-channel pulse enable
//   o_level   debounced filtered level
//   o_rise    one-cycle pulse on filtered 0->1
//   o_fall    one-cycle pulse on filtered 1->0
//   o_held    filtered level has been high for the hold delay
//   o_repeat  one-cycle auto-repeat pulse
//
// Modports:
//   master  drives the pins and enables, observes the conditioned outputs
//   slave   the conditioner itself
interface input_conditioner_if #(
  parameter int N_CH = 5
);

  logic [N_CH-1:0] i_din;
  logic [N_CH-1:0] i_chan_en;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_held;
  logic [N_CH-1:0] o_repeat;

  modport master (
    output i_din,
    output i_chan_en,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_held,
    input  o_repeat
  );

  modport slave (
    input  i_din,
    input  i_chan_en,
    output o_level,
    output o_rise,
    output o_fall,
    output o_held,
    output o_repeat
  );

endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel synchroniser, debounce, edge pulse and auto-repeat
//
// Purpose: conditions N_CH asynchronous front-panel / control inputs for the
// control FSMs. Each channel is fully independent:
//   synchroniser (SYNC_STAGES flops) -> counter debounce -> filtered level
//   -> registered rise/fall pulses -> optional hold detect with auto-repeat.
//
// Ports:
//   clk    system clock, all flops on posedge
//   reset  asynchronous active-high reset, clears every flop
//   bus    input_conditioner_if.slave
//            i_din, i_chan_en        inputs
//            o_level, o_rise, o_fall outputs (registered)
//            o_held, o_repeat        outputs (registered, 0 when REPEAT_DELAY=0)
//
// Every output is driven straight from a flop; there is no combinational
// path from i_din or i_chan_en to any output.
module input_conditioner #(
  parameter int N_CH            = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input logic                  clk,
  input logic                  reset,
  input_conditioner_if.slave   bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Hold counter only needs to reach the larger of the two intervals because
  // it reloads on every repeat pulse.
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HC_W   = $clog2(HC_MAX + 1);
  localparam int HCX_W  = HC_W + 1;

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_held;
  logic [N_CH-1:0] w_repeat;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_mismatch;
    logic                   w_toggle;

    // ------------------------------------------------------------------
    // Synchroniser: bit 0 samples the pin, the top bit is the safe copy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_din[g]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: count consecutive samples that disagree with the filtered
    // level. Any agreeing sample restarts the count, so a bounce has to
    // settle for a full DEBOUNCE_CYCLES run before the level moves. The
    // toggle happens on the edge that would take the count to
    // DEBOUNCE_CYCLES, hence the compare against DEBOUNCE_CYCLES-1.
    // ------------------------------------------------------------------
    assign w_mismatch = w_s ^ r_level;
    assign w_toggle   = w_mismatch && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        if (!w_mismatch || w_toggle) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end

        if (w_toggle) begin
          r_level <= ~r_level;
        end

        // Pulses are computed from the pre-toggle level so they land in the
        // cycle right after the level changes; rise and fall are exclusive.
        r_rise <= w_toggle & ~r_level & bus.i_chan_en[g];
        r_fall <= w_toggle &  r_level & bus.i_chan_en[g];
      end
    end

    assign w_level[g] = r_level;
    assign w_rise[g]  = r_rise;
    assign w_fall[g]  = r_fall;

    // ------------------------------------------------------------------
    // Hold detection and auto-repeat.
    // ------------------------------------------------------------------
    if (REPEAT_DELAY > 0) begin : g_hold

      logic [HC_W-1:0]  r_hc;
      logic             r_held;
      logic             r_rpt;
      logic [HCX_W-1:0] w_hc_inc;
      logic             w_due;
      logic             w_fire;

      // r_hc counts cycles since the level rose (or since the last repeat);
      // the incremented value equals the number of edges elapsed at the
      // current edge, so comparing it to the interval fires exactly on time.
      assign w_hc_inc = {1'b0, r_hc} + 1'b1;
      assign w_due    = r_held ? (w_hc_inc == HCX_W'(REPEAT_PERIOD))
                               : (w_hc_inc == HCX_W'(REPEAT_DELAY));

      // A repeat that falls due on the same edge as the level falling is
      // dropped: the release wins.
      assign w_fire = r_level && !w_toggle && w_due;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_hc   <= '0;
          r_held <= 1'b0;
          r_rpt  <= 1'b0;
        end else begin
          r_rpt <= w_fire & bus.i_chan_en[g];

          // Level low, level rising (toggle while low) and level falling
          // (toggle while high) all restart the hold qualification.
          if (!r_level || w_toggle) begin
            r_hc   <= '0;
            r_held <= 1'b0;
          end else if (w_fire) begin
            r_hc   <= '0;
            r_held <= 1'b1;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
      end

      assign w_held[g]   = r_held;
      assign w_repeat[g] = r_rpt;

    end else begin : g_no_hold

      assign w_held[g]   = 1'b0;
      assign w_repeat[g] = 1'b0;

    end

  end

  assign bus.o_level  = w_level;
  assign bus.o_rise   = w_rise;
  assign bus.o_fall   = w_fall;
  assign bus.o_held   = w_held;
  assign bus.o_repeat = w_repeat;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

  localparam int N_CH            = 5;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 10;
  localparam int REPEAT_PERIOD   = 3;

  logic clk;
  logic reset;

  int n_cmp;
  int n_err;

  input_conditioner_if #(.N_CH(N_CH)) bus ();

  input_conditioner #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset across one active edge, applies the new inputs, and releases
  // reset on a falling edge so the next posedge is edge 1.
  task automatic start_after_reset(input logic [4:0] din_v, input logic [4:0] en_v);
    reset = 1'b1;
    @(negedge clk);
    bus.i_din     = din_v;
    bus.i_chan_en = en_v;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_level"},  32'(bus.o_level),  32'h0);
    check_eq({tag, "_rise"},   32'(bus.o_rise),   32'h0);
    check_eq({tag, "_fall"},   32'(bus.o_fall),   32'h0);
    check_eq({tag, "_held"},   32'(bus.o_held),   32'h0);
    check_eq({tag, "_repeat"}, 32'(bus.o_repeat), 32'h0);
  endtask

  initial begin
    int n_rise;
    int n_fall;
    int n_rpt;

    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.i_din     = '0;
    bus.i_chan_en = 5'b11111;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Clean press on channel 0, then release
    start_after_reset(5'b00001, 5'b11111);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check_eq("press_level_e5", 32'(bus.o_level), 32'h00);
      if (e == 6) begin
        check_eq("press_level_e6", 32'(bus.o_level),  32'h01);
        check_eq("press_rise_e6",  32'(bus.o_rise),   32'h01);
        check_eq("press_fall_e6",  32'(bus.o_fall),   32'h00);
        check_eq("press_held_e6",  32'(bus.o_held),   32'h00);
        check_eq("press_rpt_e6",   32'(bus.o_repeat), 32'h00);
      end
    end
    tick();
    check_eq("press_rise_e7", 32'(bus.o_rise), 32'h00);
    bus.i_din = 5'b00000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        check_eq("release_level_r5", 32'(bus.o_level), 32'h01);
        check_eq("release_fall_r5",  32'(bus.o_fall),  32'h00);
      end
      if (e == 6) begin
        check_eq("release_level_r6", 32'(bus.o_level), 32'h00);
        check_eq("release_fall_r6",  32'(bus.o_fall),  32'h01);
        check_eq("release_rise_r6",  32'(bus.o_rise),  32'h00);
      end
    end
    tick();
    check_eq("release_fall_r7", 32'(bus.o_fall), 32'h00);

    // Bounce rejection on channel 1: high 1-3, low 4-6, high 7-9, low 10-12,
    // high from edge 13 on; level settles at edge 18.
    start_after_reset(5'b00010, 5'b11111);
    n_rise = 0;
    n_fall = 0;
    for (int e = 1; e <= 25; e++) begin
      bus.i_din[1] = (e <= 3) || (e >= 7 && e <= 9) || (e >= 13);
      tick();
      if (bus.o_rise[1]) n_rise++;
      if (bus.o_fall[1]) n_fall++;
      if (e == 12) check_eq("bounce_level_e12", 32'(bus.o_level), 32'h00);
      if (e == 17) check_eq("bounce_level_e17", 32'(bus.o_level), 32'h00);
      if (e == 18) begin
        check_eq("bounce_level_e18", 32'(bus.o_level), 32'h02);
        check_eq("bounce_rise_e18",  32'(bus.o_rise),  32'h02);
      end
    end
    check_eq("bounce_rise_count", 32'(n_rise), 32'd1);
    check_eq("bounce_fall_count", 32'(n_fall), 32'd0);

    // Hold/repeat on channel 2: high before edges 1..31, low from edge 32.
    // Level 6..36, held 16..36, repeats 16,19,...,34; the one due at 37
    // coincides with the level falling and is dropped.
    start_after_reset(5'b00100, 5'b11111);
    n_rpt = 0;
    for (int e = 1; e <= 45; e++) begin
      bus.i_din[2] = (e <= 31);
      tick();
      if (bus.o_repeat[2]) n_rpt++;
      if (e == 6)  check_eq("hold_rise_e6",  32'(bus.o_rise),   32'h04);
      if (e == 15) begin
        check_eq("hold_held_e15", 32'(bus.o_held),   32'h00);
        check_eq("hold_rpt_e15",  32'(bus.o_repeat), 32'h00);
      end
      if (e == 16) begin
        check_eq("hold_held_e16", 32'(bus.o_held),   32'h04);
        check_eq("hold_rpt_e16",  32'(bus.o_repeat), 32'h04);
      end
      if (e == 17) check_eq("hold_rpt_e17", 32'(bus.o_repeat), 32'h00);
      if (e == 18) check_eq("hold_rpt_e18", 32'(bus.o_repeat), 32'h00);
      if (e == 19) check_eq("hold_rpt_e19", 32'(bus.o_repeat), 32'h04);
      if (e == 36) begin
        check_eq("hold_held_e36",  32'(bus.o_held),  32'h04);
        check_eq("hold_level_e36", 32'(bus.o_level), 32'h04);
      end
      if (e == 37) begin
        check_eq("hold_level_e37", 32'(bus.o_level),  32'h00);
        check_eq("hold_held_e37",  32'(bus.o_held),   32'h00);
        check_eq("hold_rpt_e37",   32'(bus.o_repeat), 32'h00);
        check_eq("hold_fall_e37",  32'(bus.o_fall),   32'h04);
      end
    end
    check_eq("hold_rpt_count", 32'(n_rpt), 32'd7);

    // Mask and simultaneity
    start_after_reset(5'b11111, 5'b10101);
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 5) check_eq("mask_level_e5", 32'(bus.o_level), 32'h00);
      if (e == 6) begin
        check_eq("mask_level_e6", 32'(bus.o_level), 32'h1f);
        check_eq("mask_rise_e6",  32'(bus.o_rise),  32'h15);
        check_eq("mask_fall_e6",  32'(bus.o_fall),  32'h00);
      end
      if (e == 7) check_eq("mask_rise_e7", 32'(bus.o_rise), 32'h00);
      if (e == 16) begin
        check_eq("mask_held_e16", 32'(bus.o_held),   32'h1f);
        check_eq("mask_rpt_e16",  32'(bus.o_repeat), 32'h15);
      end
    end

    // Reset mid-debounce on channel 3
    start_after_reset(5'b01000, 5'b11111);
    for (int e = 1; e <= 4; e++) tick();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_debounce");
    @(negedge clk);
    reset = 1'b0;
    n_rise = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (bus.o_rise[3]) n_rise++;
      if (e == 5) check_eq("rst_db_level_e5", 32'(bus.o_level), 32'h00);
      if (e == 6) begin
        check_eq("rst_db_level_e6", 32'(bus.o_level), 32'h08);
        check_eq("rst_db_rise_e6",  32'(bus.o_rise),  32'h08);
      end
      if (e == 16) begin
        check_eq("rst_db_held_e16", 32'(bus.o_held),   32'h08);
        check_eq("rst_db_rpt_e16",  32'(bus.o_repeat), 32'h08);
      end
    end
    check_eq("rst_db_rise_count", 32'(n_rise), 32'd1);

    // Reset mid-hold: outputs must drop before the next clock edge
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) check_eq("rst_hold_level_e5", 32'(bus.o_level), 32'h00);
      if (e == 6) begin
        check_eq("rst_hold_level_e6", 32'(bus.o_level), 32'h08);
        check_eq("rst_hold_rise_e6",  32'(bus.o_rise),  32'h08);
      end
      if (e == 7) check_eq("rst_hold_rise_e7", 32'(bus.o_rise), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel input conditioner for asynchronous front-panel and control inputs (play, record, clip select, reset request, ...).
- Per channel:
  - parametrised-depth synchroniser;
  - counter-based debounce filter;
  - registered single-cycle rise and fall pulses;
  - optional hold detection with auto-repeat.
- Sits between the raw input pins and the control FSMs.
- Generalises the fixed 5-input, 2-flop rising-edge detector to N channels.
- Adds debounce, falling-edge output, per-channel enable and auto-repeat.

Parameters:
- N_CH, 5, number of independent channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 4, consecutive cycles of disagreement required before the filtered level changes (≥1; 1 = no filtering).
- REPEAT_DELAY, 0, cycles a filtered level must stay high before the first repeat pulse; 0 disables hold/repeat entirely.
- REPEAT_PERIOD, 8, cycles between subsequent repeat pulses (≥1; ignored when REPEAT_DELAY=0).

Ports:
- clk, input, 1, system clock; all flops on posedge.
- reset, input, 1, asynchronous, active-high; clears all state.
- din, input, N_CH, raw asynchronous inputs, bit i = channel i.
- chan_en, input, N_CH, synchronous per-channel pulse enable.
- level, output, N_CH, debounced filtered level.
- rise, output, N_CH, one-cycle pulse on filtered 0→1.
- fall, output, N_CH, one-cycle pulse on filtered 1→0.
- held, output, N_CH, high while the filtered level has been high ≥ REPEAT_DELAY cycles.
- repeat, output, N_CH, one-cycle auto-repeat pulse.

Behaviour:
- Reset (async assert): sync chain, stable level, counters, level, rise, fall, held and repeat all go to 0.
- Synchroniser: din[i] is shifted through SYNC_STAGES flops. A change that is stable before edge 1 appears at the last stage (s[i]) after edge SYNC_STAGES.
- Debounce counter:
  - cnt[i] has width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge with s[i] != level[i]: cnt increments.
  - Each edge with s[i] == level[i]: cnt clears to 0, so a bounce restarts the count.
  - On the edge where the mismatch count reaches DEBOUNCE_CYCLES, level[i] toggles and cnt clears.
- Latency: for input stable from before edge 1, level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Rise/fall:
  - rise[i] is registered and is 1 for exactly the cycle following the edge where level[i] goes 0→1, gated by chan_en[i] sampled on that edge.
  - fall[i] behaves the same for 1→0.
  - rise and fall are never both 1 on the same channel.
- Masking: chan_en=0 suppresses rise, fall and repeat only; level and held keep tracking.
- Hold/repeat (REPEAT_DELAY>0):
  - Per-channel hold counter hc[i] has width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - hc clears when level=0 and on the rising edge of level.
  - hc increments each cycle while level=1.
  - Let E be the edge where level rises. held=1 and the first repeat pulse occur at edge E+REPEAT_DELAY.
  - Further repeat pulses follow at E+REPEAT_DELAY+k·REPEAT_PERIOD, k≥1. hc reloads after each repeat, so there is no wrap-around.
  - held and repeat clear at the edge where level falls.
  - A repeat due on that same edge is dropped.
- REPEAT_DELAY=0: held and repeat are tied to 0 and the hold logic is not generated.
- Channels are fully independent. Simultaneous events on any set of channels produce simultaneous pulses.
- Reset mid-debounce or mid-hold: all state is discarded, nothing is emitted, and qualification restarts from level=0.
- Input held high through reset release produces one rise pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges. This is intended behaviour.
- No combinational path from din or chan_en to any output.

Test Plan (N_CH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, chan_en=5'b11111):
- Clean press: din[0] 0→1 before edge 1 and held → level[0]=1 at edge 6; rise[0]=1 for the single cycle after edge 6; all other outputs 0.
- Bounce rejection: din[1] toggles 1,0,1,0 at 3-cycle intervals, then stays 1 → no level change until 4 consecutive high samples at the sync output; exactly one rise[1] pulse.
- Release: channel 0 high and filtered, din[0]→0 → fall[0] pulse 6 edges later, level[0]=0; held and repeat clear on the same edge.
- Hold/repeat: din[2] held high 30 cycles → rise at E; held and repeat at E+10; repeat again at E+13, E+16, ... until release; count pulses against expected.
- Mask and simultaneity: chan_en=5'b10101, all din rise together → level=5'b11111 on one edge; rise=5'b10101 for one cycle only.
- Reset mid-operation: assert reset 2 cycles into debounce of din[3], and separately during hold → all outputs 0 immediately (asynchronously); with din[3] still high after release → single rise[3] at edge 6 after release.
